// File: rtl/lab_alu_pkg.sv
// Shared opcode and FSM state encodings for the lab_alu_seq operator unit.
package lab_alu_pkg;

    localparam logic [2:0] OP_EQ   = 3'd0;
    localparam logic [2:0] OP_ROR  = 3'd1;
    localparam logic [2:0] OP_GT   = 3'd2;
    localparam logic [2:0] OP_LAND = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_SHR  = 3'd6;
    localparam logic [2:0] OP_CADD = 3'd7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/lab_alu_comb.sv
// Single-cycle opcode evaluation; for shifts it only supplies the unshifted seed.
module lab_alu_comb
    import lab_alu_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   c,
    output logic         d
);

    always_comb begin
        c = '0;
        d = 1'b0;
        case (op)
            OP_EQ:          d = (a == b);
            OP_ROR:         d = |b;
            OP_GT:          d = (a > b);
            OP_LAND:        d = (|a) && (|b);
            OP_AND:         c = {1'b0, a & b};
            OP_SHL, OP_SHR: c = {1'b0, a};
            // a-b wraps naturally in the W+1 bit result
            OP_CADD:        c = (a > b) ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
            default:        ;
        endcase
        if (op[2]) d = |c;
    end

endmodule

// File: rtl/lab_alu_seq.sv
// Handshaked operator unit: one op in flight, shifts iterate one bit per clock.
module lab_alu_seq
    import lab_alu_pkg::*;
#(
    parameter int W  = 5,
    parameter int CW = $clog2(W+2)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   c,
    output logic         d,
    output logic         busy
);

    localparam logic [W:0]    SH_MAX = W+1;
    localparam logic [CW-1:0] N_MAX  = CW'(W+1);

    logic [1:0]    state;
    logic [2:0]    op_q;
    logic [W-1:0]  a_q, b_q;
    logic [CW-1:0] cnt, n;
    logic [W:0]    comb_c, c_sh;
    logic          comb_d, is_shift;

    lab_alu_comb #(.W(W)) u_comb (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .c  (comb_c),
        .d  (comb_d)
    );

    // Shifting W+1 or more places always empties the word, so cap the count there
    always_comb begin
        is_shift = (op_q == OP_SHL) || (op_q == OP_SHR);
        n        = ({1'b0, b_q} >= SH_MAX) ? N_MAX : CW'(b_q);
        c_sh     = (op_q == OP_SHR) ? (c >> 1) : (c << 1);
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c     <= '0;
            d     <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    op_q  <= op;
                    a_q   <= a;
                    b_q   <= b;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    c <= comb_c;
                    d <= comb_d;
                    if (is_shift && (n != '0)) begin
                        cnt   <= n;
                        state <= S_SHIFT;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_SHIFT: begin
                    c   <= c_sh;
                    d   <= |c_sh;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_DONE;
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lab_alu_seq.md
# lab_alu_seq

Parametrised, handshaked operator unit. It computes one of eight integer operations on two W-bit unsigned operands and returns a (W+1)-bit result plus a 1-bit flag. Single-cycle operations complete in one clock. Shifts are performed iteratively, one bit per clock. The unit sits between an operand source and a result sink, both using valid/ready handshakes, and holds one operation in flight at a time.

## Interface
- W, 5, operand width (W ≥ 2); result width is W+1
- CW, $clog2(W+2), width of the shift-count register

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  unit can accept an operation
- op  in  3  opcode (see Operation)
- a  in  W  operand A, unsigned
- b  in  W  operand B, unsigned; also the shift amount for SHL/SHR
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts the result
- c  out  W+1  result word
- d  out  1  result flag
- busy  out  1  high in every state except IDLE

## Operation
- Opcodes:
  - 0 EQ: d = (a==b), c = 0
  - 1 ROR: d = |b, c = 0
  - 2 GT: d = (a>b), c = 0
  - 3 LAND: d = (a≠0)&&(b≠0), c = 0
  - 4 AND: c = zero-extended a&b
  - 5 SHL: c = ({1'b0,a} << b), truncated to W+1 bits
  - 6 SHR: c = {1'b0,a} >> b
  - 7 CADD: c = (a>b) ? a+b : a−b, computed modulo 2^(W+1); the subtraction wraps in two's complement
- For opcodes 4–7, d = |c.
- States:
  - IDLE → EXEC on in_valid && in_ready.
  - EXEC → SHIFT if op ∈ {SHL, SHR} and n > 0; otherwise EXEC → DONE.
  - SHIFT shifts c by one bit and decrements the counter each cycle. SHIFT → DONE when the counter reaches 0.
  - DONE → IDLE on out_valid && out_ready.
- Shift amount n = min(b, W+1). If b ≥ W+1, the result is 0 after W+1 steps.
- Operands and opcode are captured on acceptance. Input changes after acceptance have no effect.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- There is no overlap: a new operation can be accepted no earlier than the cycle after the result is taken.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, c 0, d 0, counter 0.
- Latency is counted from the accept edge to the first cycle out_valid is high:
  - non-shift ops, and shifts with n = 0: 2 cycles
  - shifts with n > 0: 2+n cycles
- c and d are stable throughout DONE until the result is taken. out_valid stays high while out_ready is low; the unit never drops a result.
- in_valid asserted while busy is ignored (in_ready = 0) and has no side effects.
- Reset asserted mid-operation takes effect immediately:
  - the operation is aborted
  - outputs return to their reset values
  - no out_valid is produced for the aborted operation
- When out_ready and in_valid are both high in DONE, the result is taken and the new input is not accepted; IDLE accepts it on the following cycle.

## Structure
- Shared package lab_alu_pkg:
  - opcode constants OP_EQ…OP_CADD (3 bits)
  - state encoding IDLE/EXEC/SHIFT/DONE
- Sub-module lab_alu_comb: purely combinational evaluation of opcodes 0–4 and 7, plus the initial values of c for the shifts. It is parametrised by W.
- The top level holds the FSM, operand registers, shift counter and result registers.

## Test plan
With W = 5:
- Reset, then EQ with a=5, b=5 → d=1, c=0, out_valid 2 cycles after accept.
- CADD with a=5'b11011, b=4 → c=6'b011111, d=1. CADD with a=3, b=7 → c=6'b111100 (wrap).
- SHR with a=27, b=4 → c=1, out_valid at accept+6. SHL with a=27, b=4 → c=6'b110000.
- SHR with a=27, b=31 → n=6, c=0, d=0, out_valid at accept+8.
- Hold out_ready low for 5 cycles in DONE → c and d unchanged, in_ready stays 0, and a pulse on in_valid is ignored. Then raise out_ready → IDLE next cycle.
- Assert rst during SHIFT of a b=20 shift → out_valid, c, d, busy go to 0 immediately. The next accepted EQ with a=1, b=2 gives d=0.
